// File: rtl/mtr_drv.sv
// -----------------------------------------------------------------------------
// mtr_drv
//   Turns the signed left/right wheel speed commands into complementary,
//   non-overlapping PWM pairs for the two H-bridges. A shared 11-bit
//   free-running counter sets a 2048-clock PWM period. Duty values are
//   double-buffered and only change on the period boundary.
//
//   Optional feature (macro MTR_DRV_OVR_I_SHTDWN_EN): synchronizes the
//   over-current flags, ignores them inside a blanking window after PWM1
//   rises, and latches a shutdown after seven consecutive faulted periods.
//   Without the macro the over-current inputs are ignored and ovr_i_shtdwn
//   is tied low.
//
// Parameters
//   NONOVERLAP  dead time (clocks) inserted before each PWM output rises
//   BLANK       clocks after PWM1 rises during which OVR_I_* is ignored
// Ports
//   clk          system clock (50 MHz)
//   rst          synchronous active-high reset
//   lft_spd      signed 12-bit left speed command
//   rght_spd     signed 12-bit right speed command
//   OVR_I_lft    left over-current flag (asynchronous)
//   OVR_I_rght   right over-current flag (asynchronous)
//   PWM1_lft     left forward drive        PWM2_lft   left complementary drive
//   PWM1_rght    right forward drive       PWM2_rght  right complementary drive
//   ovr_i_shtdwn latched over-current shutdown flag
// -----------------------------------------------------------------------------
module mtr_drv #(
  parameter logic [10:0] NONOVERLAP = 11'h020,
  parameter logic [7:0]  BLANK      = 8'd128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        OVR_I_lft,
  input  logic        OVR_I_rght,
  output logic        PWM1_lft,
  output logic        PWM2_lft,
  output logic        PWM1_rght,
  output logic        PWM2_rght,
  output logic        ovr_i_shtdwn
);

  localparam logic [10:0] CNT_MAX  = 11'h7FF;
  localparam logic [10:0] DUTY_MID = 11'h400;

  // Clamp a signed 12-bit command to [-1024, 1023] and offset it to 0..2047.
  // The value fits in 11 signed bits exactly when bits 11 and 10 agree.
  function automatic logic [10:0] sat_duty(input logic [11:0] spd);
    logic [10:0] sat;
    if (spd[11] != spd[10]) begin
      sat = spd[11] ? 11'h400 : 11'h3FF;
    end else begin
      sat = spd[10:0];
    end
    return sat + DUTY_MID;
  endfunction

  logic [10:0] cnt_r;
  logic [10:0] duty_lft_r;
  logic [10:0] duty_rght_r;
  logic        shtdwn_s;
  logic        pwm1_lft_s;
  logic        pwm2_lft_s;
  logic        pwm1_rght_s;
  logic        pwm2_rght_s;

  // Free-running period counter, wraps 2047 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 11'd0;
    end else begin
      cnt_r <= cnt_r + 11'd1;
    end
  end

  // Duty double buffer: new commands load only on the last clock of a period.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_lft_r  <= DUTY_MID;
      duty_rght_r <= DUTY_MID;
    end else if (cnt_r == CNT_MAX) begin
      duty_lft_r  <= sat_duty(lft_spd);
      duty_rght_r <= sat_duty(rght_spd);
    end else begin
      duty_lft_r  <= duty_lft_r;
      duty_rght_r <= duty_rght_r;
    end
  end

  // Next PWM levels from the current count. The PWM2 threshold is formed at
  // 12 bits so a duty near full scale pushes it past the period (never high).
  always_comb begin
    pwm1_lft_s  = 1'b0;
    pwm2_lft_s  = 1'b0;
    pwm1_rght_s = 1'b0;
    pwm2_rght_s = 1'b0;
    if (shtdwn_s) begin
      pwm1_lft_s  = 1'b0;
      pwm2_lft_s  = 1'b0;
      pwm1_rght_s = 1'b0;
      pwm2_rght_s = 1'b0;
    end else begin
      pwm1_lft_s  = (cnt_r >= NONOVERLAP) && (cnt_r < duty_lft_r);
      pwm2_lft_s  = ({1'b0, cnt_r} >= ({1'b0, duty_lft_r} + {1'b0, NONOVERLAP}));
      pwm1_rght_s = (cnt_r >= NONOVERLAP) && (cnt_r < duty_rght_r);
      pwm2_rght_s = ({1'b0, cnt_r} >= ({1'b0, duty_rght_r} + {1'b0, NONOVERLAP}));
    end
  end

  // Output registers driving the bridge pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      PWM1_lft  <= 1'b0;
      PWM2_lft  <= 1'b0;
      PWM1_rght <= 1'b0;
      PWM2_rght <= 1'b0;
    end else begin
      PWM1_lft  <= pwm1_lft_s;
      PWM2_lft  <= pwm2_lft_s;
      PWM1_rght <= pwm1_rght_s;
      PWM2_rght <= pwm2_rght_s;
    end
  end

`ifdef MTR_DRV_OVR_I_SHTDWN_EN
  localparam logic [11:0] BLANK_END = {1'b0, NONOVERLAP} + {4'b0000, BLANK};

  // Step a consecutive-fault counter at the period boundary; holds at 7.
  function automatic logic [2:0] fault_step(input logic [2:0] cnt, input logic hit);
    logic [2:0] nxt;
    if (!hit) begin
      nxt = 3'd0;
    end else if (cnt == 3'd7) begin
      nxt = 3'd7;
    end else begin
      nxt = cnt + 3'd1;
    end
    return nxt;
  endfunction

  logic [1:0] sync_lft_r;
  logic [1:0] sync_rght_r;
  logic       seen_lft_r;
  logic       seen_rght_r;
  logic [2:0] fcnt_lft_r;
  logic [2:0] fcnt_rght_r;
  logic       shtdwn_r;
  logic       qual_lft_s;
  logic       qual_rght_s;

  // Two-flop synchronizers for the asynchronous over-current flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_lft_r  <= 2'b00;
      sync_rght_r <= 2'b00;
    end else begin
      sync_lft_r  <= {sync_lft_r[0], OVR_I_lft};
      sync_rght_r <= {sync_rght_r[0], OVR_I_rght};
    end
  end

  // A fault only counts while the forward drive is on and past blanking.
  always_comb begin
    qual_lft_s  = sync_lft_r[1] && PWM1_lft && ({1'b0, cnt_r} >= BLANK_END);
    qual_rght_s = sync_rght_r[1] && PWM1_rght && ({1'b0, cnt_r} >= BLANK_END);
  end

  // Per-period fault memory and consecutive-period counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_lft_r  <= 1'b0;
      seen_rght_r <= 1'b0;
      fcnt_lft_r  <= 3'd0;
      fcnt_rght_r <= 3'd0;
    end else if (cnt_r == CNT_MAX) begin
      seen_lft_r  <= 1'b0;
      seen_rght_r <= 1'b0;
      fcnt_lft_r  <= fault_step(fcnt_lft_r, seen_lft_r || qual_lft_s);
      fcnt_rght_r <= fault_step(fcnt_rght_r, seen_rght_r || qual_rght_s);
    end else begin
      seen_lft_r  <= seen_lft_r || qual_lft_s;
      seen_rght_r <= seen_rght_r || qual_rght_s;
      fcnt_lft_r  <= fcnt_lft_r;
      fcnt_rght_r <= fcnt_rght_r;
    end
  end

  // Sticky shutdown: either side reaching seven faulted periods kills both.
  always_ff @(posedge clk) begin
    if (rst) begin
      shtdwn_r <= 1'b0;
    end else if ((fcnt_lft_r == 3'd7) || (fcnt_rght_r == 3'd7)) begin
      shtdwn_r <= 1'b1;
    end else begin
      shtdwn_r <= shtdwn_r;
    end
  end

  assign shtdwn_s     = shtdwn_r;
  assign ovr_i_shtdwn = shtdwn_r;
`else
  // Over-current inputs are not used in this build.
  logic unused_ovr;
  assign unused_ovr   = OVR_I_lft ^ OVR_I_rght;
  assign shtdwn_s     = 1'b0;
  assign ovr_i_shtdwn = 1'b0;
`endif

endmodule

// File: tb/tb_mtr_drv.sv
// -----------------------------------------------------------------------------
// tb_mtr_drv
//   Directed bench for mtr_drv. Runs whole PWM periods aligned to the
//   counter, counts high clocks and edge positions per output, and compares
//   them with hand-computed values. A background monitor tracks overlap and
//   dead-time violations across the whole run.
// -----------------------------------------------------------------------------
module tb_mtr_drv;

  logic        clk;
  logic        rst;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        OVR_I_lft;
  logic        OVR_I_rght;
  logic        PWM1_lft;
  logic        PWM2_lft;
  logic        PWM1_rght;
  logic        PWM2_rght;
  logic        ovr_i_shtdwn;

  mtr_drv dut (
    .clk          (clk),
    .rst          (rst),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .OVR_I_lft    (OVR_I_lft),
    .OVR_I_rght   (OVR_I_rght),
    .PWM1_lft     (PWM1_lft),
    .PWM2_lft     (PWM2_lft),
    .PWM1_rght    (PWM1_rght),
    .PWM2_rght    (PWM2_rght),
    .ovr_i_shtdwn (ovr_i_shtdwn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-period measurements.
  int h1l, h2l, h1r, h2r;
  int f1l, l1l, f2l, l2l;

  // Background overlap / dead-time monitor state.
  int low_l = 0, low_r = 0;
  int ovl_l = 0, ovl_r = 0;
  int gap_l = 0, gap_r = 0;
  logic p1l = 1'b0, p2l = 1'b0, p1r = 1'b0, p2r = 1'b0;

`ifdef MTR_DRV_OVR_I_SHTDWN_EN
  localparam int SHT_EXP = 1;
  localparam int RUN_EXP = 0;
`else
  localparam int SHT_EXP = 0;
  localparam int RUN_EXP = 992;
`endif

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Dead time: both outputs low for >= 32 samples before any rise.
  always @(negedge clk) begin
    if (rst) begin
      low_l <= 0;
      low_r <= 0;
      p1l <= 1'b0; p2l <= 1'b0; p1r <= 1'b0; p2r <= 1'b0;
    end else begin
      if (PWM1_lft && PWM2_lft) ovl_l <= ovl_l + 1;
      if (PWM1_rght && PWM2_rght) ovl_r <= ovl_r + 1;
      if (((PWM1_lft && !p1l) || (PWM2_lft && !p2l)) && (low_l < 32)) gap_l <= gap_l + 1;
      if (((PWM1_rght && !p1r) || (PWM2_rght && !p2r)) && (low_r < 32)) gap_r <= gap_r + 1;
      low_l <= (PWM1_lft || PWM2_lft) ? 0 : low_l + 1;
      low_r <= (PWM1_rght || PWM2_rght) ? 0 : low_r + 1;
      p1l <= PWM1_lft; p2l <= PWM2_lft; p1r <= PWM1_rght; p2r <= PWM2_rght;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One aligned period: sample k shows the outputs computed from cnt == k.
  // Optional command change and OVR_I_lft pulse at given sample indices.
  task automatic run_period(input int chg_at, input logic [11:0] nl,
                            input logic [11:0] nr, input int pulse_at);
    h1l = 0; h2l = 0; h1r = 0; h2r = 0;
    f1l = -1; l1l = -1; f2l = -1; l2l = -1;
    for (int k = 0; k < 2048; k++) begin
      @(posedge clk);
      #1;
      if (PWM1_lft) begin h1l++; if (f1l < 0) f1l = k; l1l = k; end
      if (PWM2_lft) begin h2l++; if (f2l < 0) f2l = k; l2l = k; end
      if (PWM1_rght) h1r++;
      if (PWM2_rght) h2r++;
      if (k == chg_at) begin lft_spd = nl; rght_spd = nr; end
      if (k == pulse_at) OVR_I_lft = 1'b1;
      if (k == pulse_at + 3) OVR_I_lft = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    lft_spd = 12'h000;
    rght_spd = 12'h7FF;
    OVR_I_lft = 1'b0;
    OVR_I_rght = 1'b0;

    // Reset state.
    @(posedge clk);
    #1;
    check_val("rst_pwm1_lft", int'(PWM1_lft), 0);
    check_val("rst_pwm2_lft", int'(PWM2_lft), 0);
    check_val("rst_pwm1_rght", int'(PWM1_rght), 0);
    check_val("rst_pwm2_rght", int'(PWM2_rght), 0);
    check_val("rst_shtdwn", int'(ovr_i_shtdwn), 0);
    do_reset();

    // Period 0: buffers still hold the 50% reset duty on both sides.
    run_period(-1, 12'h000, 12'h000, -1);
    check_val("p0_h1l", h1l, 992);
    check_val("p0_h1r", h1r, 992);
    check_val("p0_h2r", h2r, 992);

    // Period 1: left 50%, right saturated to 2047.
    run_period(0, 12'h000, 12'h800, -1);
    check_val("p1_h1l", h1l, 992);
    check_val("p1_f1l", f1l, 32);
    check_val("p1_l1l", l1l, 1023);
    check_val("p1_h2l", h2l, 992);
    check_val("p1_f2l", f2l, 1056);
    check_val("p1_l2l", l2l, 2047);
    check_val("p1_h1r_sat_hi", h1r, 2015);
    check_val("p1_h2r_sat_hi", h2r, 0);

    // Period 2: right saturated to duty 0.
    run_period(0, 12'h000, 12'hE00, -1);
    check_val("p2_h1r_sat_lo", h1r, 0);
    check_val("p2_h2r_sat_lo", h2r, 2016);

    // Period 3: right at -512 (duty 512); left changes mid-period.
    run_period(500, 12'h200, 12'h400, -1);
    check_val("p3_h1l_keep", h1l, 992);
    check_val("p3_h1r_neg", h1r, 480);
    check_val("p3_h2r_neg", h2r, 1504);

    // Period 4: left duty 1536; right command 1024 clamps to 2047.
    run_period(-1, 12'h000, 12'h000, -1);
    check_val("p4_h1l", h1l, 1504);
    check_val("p4_f1l", f1l, 32);
    check_val("p4_l1l", l1l, 1535);
    check_val("p4_h2l", h2l, 480);
    check_val("p4_f2l", f2l, 1568);
    check_val("p4_h1r_clamp", h1r, 2015);
    check_val("p4_h2r_clamp", h2r, 0);

    // Reset in the middle of a period while both PWM1 outputs are high.
    repeat (700) @(posedge clk);
    #1;
    check_val("mid_pre_pwm1_lft", int'(PWM1_lft), 1);
    check_val("mid_pre_pwm1_rght", int'(PWM1_rght), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("mid_rst_pwm1_lft", int'(PWM1_lft), 0);
    check_val("mid_rst_pwm2_lft", int'(PWM2_lft), 0);
    check_val("mid_rst_pwm1_rght", int'(PWM1_rght), 0);
    check_val("mid_rst_pwm2_rght", int'(PWM2_rght), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_period(-1, 12'h000, 12'h000, -1);
    check_val("post_rst_h1l", h1l, 992);
    check_val("post_rst_f1l", f1l, 32);
    check_val("post_rst_h1r", h1r, 992);

    // Over-current: faults inside blanking never count.
    lft_spd = 12'h000;
    rght_spd = 12'h000;
    do_reset();
    for (int p = 0; p < 10; p++) run_period(-1, 12'h000, 12'h000, 100);
    check_val("ovr_blank_shtdwn", int'(ovr_i_shtdwn), 0);

    // Six faulted periods, one clean, six more: counter restarts.
    for (int p = 0; p < 6; p++) run_period(-1, 12'h000, 12'h000, 400);
    run_period(-1, 12'h000, 12'h000, -1);
    for (int p = 0; p < 6; p++) run_period(-1, 12'h000, 12'h000, 400);
    check_val("ovr_skip_shtdwn", int'(ovr_i_shtdwn), 0);

    // Seven consecutive faulted periods latch shutdown.
    do_reset();
    for (int p = 0; p < 7; p++) run_period(-1, 12'h000, 12'h000, 400);
    run_period(-1, 12'h000, 12'h000, -1);
    check_val("ovr_7_shtdwn", int'(ovr_i_shtdwn), SHT_EXP);
    check_val("ovr_7_h1l", h1l, RUN_EXP);
    check_val("ovr_7_h2l", h2l, RUN_EXP);
    check_val("ovr_7_h1r", h1r, RUN_EXP);
    check_val("ovr_7_h2r", h2r, RUN_EXP);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("ovr_rst_clear", int'(ovr_i_shtdwn), 0);
    rst = 1'b0;
    @(negedge clk);

    // Whole-run invariants.
    check_val("overlap_lft", ovl_l, 0);
    check_val("overlap_rght", ovl_r, 0);
    check_val("deadtime_lft", gap_l, 0);
    check_val("deadtime_rght", gap_r, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mtr_drv.md
# mtr_drv

Converts the signed wheel speed commands from the balance controller (`lft_spd`, `rght_spd`) into complementary, non-overlapping PWM pairs for the left and right H-bridges. It sits directly downstream of the balance controller and drives the motor-driver pins at the chip boundary. Duty updates are double-buffered on the PWM period boundary. An optional over-current shutdown path latches all bridges off after repeated faults.

## Interface
- `NONOVERLAP`, 11'h020: dead time in clocks, inserted before each PWM output rises.
- `BLANK`, 8'd128: blanking window in clocks after `PWM1_*` rises, during which `OVR_I_*` is ignored.
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: reset, synchronous, active-high. All state clears on the `clk` edge where `rst`=1.
- `lft_spd` in 12: signed left motor speed command.
- `rght_spd` in 12: signed right motor speed command.
- `OVR_I_lft` in 1: left bridge over-current flag, active high, asynchronous to `clk`.
- `OVR_I_rght` in 1: right bridge over-current flag, active high, asynchronous to `clk`.
- `PWM1_lft` out 1: left high-side-forward drive.
- `PWM2_lft` out 1: left complementary drive.
- `PWM1_rght` out 1: right high-side-forward drive.
- `PWM2_rght` out 1: right complementary drive.
- `ovr_i_shtdwn` out 1: latched over-current shutdown flag.

## Operation
- One shared 11-bit free-running counter `cnt`. It counts 0→2047 and wraps, giving a 2048-clock period (about 24.4 kHz).
- Saturation, per side: the signed 12-bit command is clamped to the 11-bit signed range [-1024, 1023].
- Duty is computed as `duty = sat + 11'h400`, giving an unsigned 0..2047.
- Duty buffering: `duty_buf_*` loads the new duty when `cnt`==2047. A command change therefore takes effect from the next `cnt`==0. Commands changing mid-period never alter the current period.
- Registered next-state logic for each side, computed from the current `cnt`:
  - `PWM1` = (`cnt` >= NONOVERLAP) && (`cnt` < `duty_buf`).
  - `PWM2` = (`cnt` >= `duty_buf` + NONOVERLAP). This sum is formed at 12 bits; a sum above 2047 means `PWM2` stays low for the whole period.
- By construction `PWM1` and `PWM2` are never high together, and each rising edge is preceded by at least NONOVERLAP clocks with both low.
- Duty extremes:
  - `duty_buf`=0: `PWM1` never asserts.
  - `duty_buf`=2047: `PWM2` never asserts.
- `OVR_I_*` handling is described under Configuration. When `ovr_i_shtdwn`=1, all four PWM outputs are forced low at their registers.

## Timing
- Reset values:
  - `cnt`=0 and both `duty_buf`=11'h400 (50%).
  - All PWM outputs and `ovr_i_shtdwn` are 0.
  - The fault counters are 0.
- Latency:
  - The PWM outputs reflect `cnt` from the previous cycle (1-clock pipeline).
  - A command presented while `cnt`==2047 is first visible on the PWM outputs one clock after `cnt`==0.
  - The worst-case command-to-output delay is 2049 clocks.
- Reset mid-period: on the next edge all outputs drop low and `cnt` restarts at 0. Previous duty and fault history are discarded.
- With 50% duty and NONOVERLAP=32:
  - `PWM1` is high for `cnt`=32..1023.
  - `PWM2` is high for `cnt`=1056..2047.
  - Each is high for 992 clocks per period.

## Configuration
- Macro: `MTR_DRV_OVR_I_SHTDWN_EN`.
- When defined:
  - Each `OVR_I_*` passes through a 2-flop synchronizer.
  - A synchronized `OVR_I_*` is qualified when the matching `PWM1_*` is high and `cnt` >= NONOVERLAP+BLANK.
  - Each side has a 3-bit counter:
    - At `cnt`==2047, the counter increments if any qualified fault occurred in that period, otherwise it clears to 0.
    - When it reaches 7 (seven consecutive faulted periods), `ovr_i_shtdwn` sets on the next clock.
  - `ovr_i_shtdwn` is sticky; only `rst` clears it.
  - A single flag covers both sides, and a shutdown kills both bridges.
- When not defined:
  - The `OVR_I_*` inputs are ignored, and no synchronizer or counter logic is built.
  - `ovr_i_shtdwn` is tied to 0.

## Test plan
- Reset, then `lft_spd`=0: `PWM1_lft` is high exactly 992 clocks per period (`cnt` 32..1023, seen 1 clock later). `PWM2_lft` is high exactly 992 clocks per period (`cnt` 1056..2047).
- `rght_spd`=12'h7FF (saturates to duty 2047): `PWM1_rght` is high for 2015 clocks per period and `PWM2_rght` stays low.
- `rght_spd`=12'h800 (saturates to duty 0): `PWM1_rght` stays low and `PWM2_rght` is high for 2016 clocks per period.
- Change `lft_spd` from 0 to 12'h200 at `cnt`=500: the current period keeps the 992-clock high time, and the next period shows `PWM1_lft` high for `cnt` 32..1535.
- Check across all of the above: `PWM1_*` and `PWM2_*` are never high together, and the gap between them is always >= 32 clocks.
- With `MTR_DRV_OVR_I_SHTDWN_EN` defined:
  - Pulse `OVR_I_lft` at `cnt`=100 (inside blanking) for 10 periods: no shutdown.
  - Pulse it at `cnt`=400 for 6 periods, then skip 1 period, then 6 more periods: no shutdown.
  - Pulse it for 7 consecutive periods: `ovr_i_shtdwn`=1 and all PWM outputs stay low until `rst` is applied.
